// File: rtl/xor_accum.sv
// ---------------------------------------------------------------------------
// xor_accum
//
// Frame-based XOR accumulator. Each accepted beat contributes (a ^ b) to a
// running XOR. The beat flagged with in_last closes the frame, and the
// result is presented on y/parity/beats/ovf with out_valid until the
// consumer takes it with out_ready. No beat is accepted while a result is
// pending, so backpressure is applied through in_ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   a, b       in   WIDTH   operands of the current beat
//   in_valid   in   1       beat offered on a/b
//   in_last    in   1       final beat of the frame (qualified by in_valid)
//   in_ready   out  1       a beat is accepted this cycle if in_valid is high
//   y          out  WIDTH   XOR of (a ^ b) over every beat of the frame
//   parity     out  1       reduction XOR of y
//   beats      out  CNT_W   beat count of the frame, saturating
//   ovf        out  1       frame was longer than 2^CNT_W-1 beats
//   out_valid  out  1       y/parity/beats/ovf hold a completed frame
//   out_ready  in   1       consumer takes the result
// ---------------------------------------------------------------------------
module xor_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic [CNT_W-1:0] beats,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // no frame open
        S_ACCUM = 2'd1,  // frame open, at least one beat taken
        S_HOLD  = 2'd2   // result presented, waiting for out_ready
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_int_q;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] beats_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;

    // Accumulator/counter value after the beat currently on a/b. Shared by
    // the mid-frame update and the result load on the last beat, so the
    // last beat is folded into the result without an extra cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        acc_d = a ^ b;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
        if (state_q == S_ACCUM) begin
            acc_d = acc_q ^ a ^ b;
            if (cnt_q == CNT_MAX) begin
                // Saturate rather than wrap; remember that a beat was lost.
                cnt_d = cnt_q;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                ovf_d = ovf_int_q;
            end
        end
    end

    // Single FSM process; every output except the decodes below is a register.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_int_q   <= 1'b0;
            y_q         <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (in_valid) begin
                        acc_q     <= acc_d;
                        cnt_q     <= cnt_d;
                        ovf_int_q <= ovf_d;
                        if (in_last) begin
                            y_q         <= acc_d;
                            beats_q     <= cnt_d;
                            ovf_q       <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    // y/beats/ovf are left alone so they keep the last
                    // frame's values after out_valid drops.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q != S_HOLD);
    assign y         = y_q;
    assign parity    = ^y_q;
    assign beats     = beats_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_xor_accum.sv
// ---------------------------------------------------------------------------
// tb_xor_accum
//
// Drives frames into xor_accum and compares every result against a frame
// model computed from the list of beats in the frame: the XOR of all
// (a ^ b), the beat count clipped to 2^CNT_W-1, and an overflow flag for
// frames longer than that. Directed frames cover the single-beat, multi-beat,
// backpressure, overflow, reset and bubble cases; a randomized loop follows.
// ---------------------------------------------------------------------------
module tb_xor_accum;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             parity;
    logic [CNT_W-1:0] beats;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    xor_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .y         (y),
        .parity    (parity),
        .beats     (beats),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Current frame and its expected result.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] exp_y;
    int               exp_beats;
    logic             exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic new_frame();
        qa.delete();
        qb.delete();
    endtask

    task automatic add_beat(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        qa.push_back(va);
        qb.push_back(vb);
    endtask

    // Expected result of the current frame, from the beat list.
    task automatic model();
        int n;
        n     = qa.size();
        exp_y = '0;
        foreach (qa[i]) exp_y = exp_y ^ qa[i] ^ qb[i];
        exp_beats = (n > MAXC) ? MAXC : n;
        exp_ovf   = (n > MAXC);
    endtask

    // Offer each beat of the frame; in_last on the final one when close=1.
    // Bubbles put random junk (including in_last) on the bus with in_valid low.
    task automatic send_frame(input int min_gap, input int max_gap, input bit close);
        for (int i = 0; i < qa.size(); i++) begin
            check("in_ready_beat", 32'(in_ready), 32'd1);
            a        = qa[i];
            b        = qb[i];
            in_last  = close && (i == qa.size() - 1);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i != qa.size() - 1) begin
                repeat ($urandom_range(max_gap, min_gap)) begin
                    a       = WIDTH'($urandom);
                    b       = WIDTH'($urandom);
                    in_last = 1'($urandom);
                    @(posedge clk); #1;
                end
                in_last = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_y"},      32'(y),      32'(exp_y));
        check({tag, "_parity"}, 32'(parity), 32'(^exp_y));
        check({tag, "_beats"},  32'(beats),  32'(exp_beats));
        check({tag, "_ovf"},    32'(ovf),    32'(exp_ovf));
    endtask

    // Called one step after the edge that took the last beat.
    task automatic check_result(input int hold, input bit junk);
        model();
        check("res_valid", 32'(out_valid), 32'd1);
        check_outputs("res");
        if (junk) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            in_last  = 1'($urandom);
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_in_ready", 32'(in_ready),  32'd0);
            check("hold_valid",    32'(out_valid), 32'd1);
            check_outputs("hold");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("drop_ready", 32'(in_ready),  32'd1);
        check_outputs("retain");
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_y"},         32'(y),         32'd0);
        check({tag, "_parity"},    32'(parity),    32'd0);
        check({tag, "_beats"},     32'(beats),     32'd0);
        check({tag, "_ovf"},       32'(ovf),       32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #2;
        check_reset_state("por");
        @(posedge clk); #1;
        release_reset();

        // Single beat.
        new_frame();
        add_beat(8'h0F, 8'h01);
        send_frame(0, 0, 1'b1);
        check("single_y_const", 32'(y), 32'h0E);
        check_result(0, 1'b0);

        // Four beats setting one bit each.
        new_frame();
        add_beat(8'h00, 8'h01);
        add_beat(8'h00, 8'h02);
        add_beat(8'h00, 8'h04);
        add_beat(8'h00, 8'h08);
        send_frame(0, 0, 1'b1);
        check("four_y_const", 32'(y), 32'h0F);
        check_result(0, 1'b0);

        // Backpressure: 5 cycles held with a junk beat offered; the next
        // frame must not contain it.
        new_frame();
        add_beat(8'h3C, 8'h81);
        add_beat(8'h55, 8'h0F);
        send_frame(0, 0, 1'b1);
        check_result(5, 1'b1);
        new_frame();
        add_beat(8'h12, 8'h34);
        send_frame(0, 0, 1'b1);
        check_result(0, 1'b0);

        // Overflow: 17 beats, then a 2-beat frame clears the flag.
        new_frame();
        repeat (17) add_beat(8'h01, 8'h00);
        send_frame(0, 0, 1'b1);
        check("ovf17_beats_const", 32'(beats), 32'd15);
        check("ovf17_ovf_const",   32'(ovf),   32'd1);
        check_result(1, 1'b0);
        new_frame();
        add_beat(8'hC3, 8'h11);
        add_beat(8'h7E, 8'h24);
        send_frame(0, 0, 1'b1);
        check_result(0, 1'b0);

        // Exactly 15 and 16 beats either side of the saturation point.
        for (int n = 15; n <= 16; n++) begin
            new_frame();
            repeat (n) add_beat(WIDTH'($urandom), WIDTH'($urandom));
            send_frame(0, 1, 1'b1);
            check_result(0, 1'b0);
        end

        // Bubbles: the same 3-beat frame with and without gaps.
        for (int g = 0; g <= 2; g += 2) begin
            new_frame();
            add_beat(8'hA5, 8'h18);
            add_beat(8'h66, 8'h01);
            add_beat(8'hF0, 8'h0C);
            send_frame(g, g, 1'b1);
            check_result(0, 1'b0);
        end

        // Randomized frames, gaps and hold times.
        for (int f = 0; f < 40; f++) begin
            new_frame();
            repeat ($urandom_range(20, 1)) add_beat(WIDTH'($urandom), WIDTH'($urandom));
            send_frame(0, 2, 1'b1);
            check_result($urandom_range(3, 0), 1'($urandom));
        end

        // Reset while a result is pending.
        new_frame();
        add_beat(8'h0F, 8'h01);
        send_frame(0, 0, 1'b1);
        model();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_hold");
        release_reset();

        // Reset mid-frame after 3 beats, then a fresh single-beat frame.
        new_frame();
        add_beat(8'h11, 8'h22);
        add_beat(8'h33, 8'h44);
        add_beat(8'h55, 8'h66);
        send_frame(0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_mid");
        release_reset();
        new_frame();
        add_beat(8'hAA, 8'h00);
        send_frame(0, 0, 1'b1);
        check("post_rst_y_const",     32'(y),     32'hAA);
        check("post_rst_beats_const", 32'(beats), 32'd1);
        check_result(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_accum.md
XOR_ACCUM -- requirements
Module: xor_accum

Interface
REQ-001 Parameter: WIDTH, default 8, data width of operands and result.
REQ-002 Parameter: CNT_W, default 4, width of the beat counter.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: in_valid  input  1  beat offered on a/b.
REQ-009 Port: in_last  input  1  beat is the final beat of a frame; qualified by in_valid.
REQ-010 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-011 Port: y  output  WIDTH  frame result, XOR of (a^b) over all beats in the frame.
REQ-012 Port: parity  output  1  reduction XOR of y.
REQ-013 Port: beats  output  CNT_W  number of beats in the frame, saturating.
REQ-014 Port: ovf  output  1  frame beat count exceeded 2^CNT_W-1.
REQ-015 Port: out_valid  output  1  y/parity/beats/ovf hold a completed frame.
REQ-016 Port: out_ready  input  1  consumer takes the result.

Function
REQ-017 The module SHALL be a 3-state FSM: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
REQ-018 A beat SHALL be accepted when in_valid && in_ready, with in_ready = 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 IDLE, accepted beat, !in_last: acc <= a^b, cnt <= 1, -> ACCUM.
REQ-020 ACCUM, accepted beat, !in_last: acc <= acc^(a^b), cnt <= cnt+1 saturating at 2^CNT_W-1, ovf_int set when an increment is attempted at saturation.
REQ-021 An accepted beat with in_last (IDLE or ACCUM) SHALL load y <= acc_next, beats <= cnt_next, ovf <= ovf_next, out_valid <= 1 and go to HOLD; the result is visible the cycle after the last beat.
REQ-022 A single-beat frame (in_last on the first beat from IDLE) SHALL yield y = a^b, beats = 1.
REQ-023 In HOLD, outputs SHALL stay stable until out_ready = 1; on that edge out_valid <= 0 and state -> IDLE; no beat is accepted on that cycle.
REQ-024 ACCUM with in_valid = 0 SHALL hold acc and cnt unchanged (bubbles allowed).
REQ-025 parity SHALL equal ^y combinationally from the registered y.
REQ-026 y, beats and ovf SHALL retain the last frame's values after out_valid drops, until the next frame completes.
REQ-027 in_last without in_valid SHALL be ignored.
REQ-028 Saturation: beats SHALL never wrap; ovf = 1 only for frames longer than 2^CNT_W-1 beats, and ovf_int SHALL clear when a new frame starts.

Reset
REQ-029 On rst_n = 0, asynchronously: state = IDLE, acc = 0, cnt = 0, y = 0, beats = 0, ovf = 0, out_valid = 0; in_ready = 1 and parity = 0 follow.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result; the first accepted beat after release starts a new frame.
REQ-031 Release of rst_n SHALL take effect synchronously on the next rising edge of clk.

Verification
REQ-032 Single beat a=8'h0F, b=8'h01, in_last=1 -> next cycle out_valid=1, y=8'h0E, parity=1, beats=1, ovf=0.
REQ-033 Four beats (a,b) = (00,01),(00,02),(00,04),(00,08), last on the 4th -> y=8'h0F, parity=0, beats=4.
REQ-034 Backpressure: out_ready=0 for 5 cycles after the result, in_valid=1 held -> in_ready=0, y stable, no beat consumed; out_ready=1 -> out_valid=0 next cycle, and the following beat starts a new frame.
REQ-035 Overflow with CNT_W=4: 17 beats of a=8'h01, b=0 -> beats=15, ovf=1, y=8'h01; the next 2-beat frame -> beats=2, ovf=0.
REQ-036 Reset mid-frame after 3 beats, then a 1-beat frame a=8'hAA, b=0 -> y=8'hAA, beats=1; all outputs 0 during reset.
REQ-037 Bubbles: 3-beat frame with in_valid low for 2 cycles between beats -> same y/beats as with no gaps.
